flex_down_counter: RTL

//  Programmable down-counting timer that pairs with the rollover up-counter.
//  It is loaded with an N-bit value, decrements once per enabled cycle, and

---
 rtl/flex_cnt_pkg.sv | 11 +
 rtl/flex_down_counter.sv | 80 ++++++++
 2 files changed

// File: rtl/flex_cnt_pkg.sv
// Shared types for the flexible counter family.
// State encoding used by the programmable down-counter.
package flex_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } dcnt_state_t;

endpackage

// File: rtl/flex_down_counter.sv
// Programmable down-counting timer, one-shot or auto-reload.
// Reports terminal count and a one-cycle pulse per finished countdown.
module flex_down_counter
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    count_enable,
  input  logic                    periodic,
  input  logic [NUM_CNT_BITS-1:0] reload_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    terminal_flag,
  output logic                    done_pulse,
  output logic                    busy
);

  localparam logic [NUM_CNT_BITS-1:0] ONE =
    {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  dcnt_state_t             state_q, state_d;
  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                    term_q, term_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      // A zero reload would park RUN at 0, so it is dropped.
      if (reload_val != '0) begin
        state_d = RUN;
        cnt_d   = reload_val;
      end
    end else if (state_q == RUN && count_enable) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else begin
        done_d = 1'b1;
        if (periodic && reload_val != '0) begin
          cnt_d = reload_val;
        end else begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
    end
  end

  always_comb begin
    term_d = (state_d == RUN) && (cnt_d == ONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      term_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      done_q  <= done_d;
    end
  end

  assign count_out     = cnt_q;
  assign terminal_flag = term_q;
  assign done_pulse    = done_q;
  assign busy          = (state_q == RUN);

endmodule
